// File: rtl/divider.sv
// Sequential 32-bit restoring divider: 32 shift-subtract steps per operation, divide-by-zero fast path.
// Signed DIV support is compiled in only when DIVIDER_SIGNED_EN is defined; otherwise unsigned only.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;

  always_comb begin
    a_mag = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Quotient negated on differing signs; remainder follows the dividend.
  always_comb begin
    res_q = neg_q ? (~step_q + 1'b1) : step_q;
    res_r = neg_r ? (~step_r + 1'b1) : step_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sign & a[WIDTH-1];
    end
  end
`else
  logic unused_sign;
  assign unused_sign = sign;

  always_comb begin
    a_mag = a;
    b_mag = b;
    res_q = step_q;
    res_r = step_r;
  end
`endif

  // One restoring step: 33-bit trial subtraction, keep the result only if non-negative.
  always_comb begin
    part = {acc_r, acc_q[WIDTH-1]};
    diff = part - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      step_r = diff[WIDTH-1:0];
      step_q = {acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_r = part[WIDTH-1:0];
      step_q = {acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_STEP) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc_q <= '0;
      acc_r <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b == '0) begin
              quo <= '1;
              rem <= a;
              dbz <= 1'b1;
            end else begin
              acc_q <= a_mag;
              acc_r <= '0;
              dvs   <= b_mag;
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          acc_q <= step_q;
          acc_r <= step_r;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            quo <= res_q;
            rem <= res_r;
            dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider; expectations follow whether DIVIDER_SIGNED_EN is defined.
module tb_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dbz;

  int n_tests = 0;
  int n_fail  = 0;

  divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one operation, scrambles inputs after the start edge, and pokes start mid-CALC.
  task automatic run_op(input string tag, input logic s, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] eq, input logic [31:0] er, input logic ed, input int elat);
    int lat;
    @(negedge clk);
    start = 1'b1;
    sign  = s;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'h0000_0009;
    b     = 32'h0000_0000;
    sign  = ~s;
    check({tag, ".busy0"}, {31'b0, busy}, {31'b0, ~ed});
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b1;
      if (lat == 2) start = 1'b0;
    end
    start = 1'b0;
    check({tag, ".lat"}, lat, elat);
    check({tag, ".quo"}, quo, eq);
    check({tag, ".rem"}, rem, er);
    check({tag, ".dbz"}, {31'b0, dbz}, {31'b0, ed});
    check({tag, ".busy_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, ".hold_quo"}, quo, eq);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.quo", quo, 32'd0);
    check("rst.rem", rem, 32'd0);
    check("rst.dbz", {31'b0, dbz}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run_op("u1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32);
    run_op("u5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32);
    run_op("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    run_op("umax_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
    run_op("dbz_u", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    run_op("u_after_dbz", 1'b0, 32'd50, 32'd8, 32'd6, 32'd2, 1'b0, 32);
    run_op("dbz_s", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 0);
`ifdef DIVIDER_SIGNED_EN
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32);
`else
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 32);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
`endif
    run_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32);
    run_op("u_nz_before_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, 32);

    // Interrupted operation: start at cycle 0, ignored start at cycle 5, reset during cycle 10.
    @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mid.busy", {31'b0, busy}, 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.busy", {31'b0, busy}, 32'd0);
    check("arst.done", {31'b0, done}, 32'd0);
    check("arst.quo", quo, 32'd0);
    check("arst.rem", rem, 32'd0);
    check("arst.dbz", {31'b0, dbz}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("arst.no_done", {31'b0, done}, 32'd0);
    end
    #1;
    rst_n = 1'b1;
    run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: sign  input  1  1 = signed operation (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port: a  input  32  dividend; sampled with start.
REQ-007 SHALL have port: b  input  32  divisor; sampled with start.
REQ-008 SHALL have port: busy  output  1  high while in CALC.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; quo/rem/dbz are valid in that cycle.
REQ-010 SHALL have port: quo  output  32  quotient.
REQ-011 SHALL have port: rem  output  32  remainder.
REQ-012 SHALL have port: dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with start=1 and b!=0 at edge E0, latch a, b and sign, enter CALC and set busy=1.
REQ-015 SHALL perform one restoring shift-subtract step per edge for edges E1..E32; at E32 it SHALL enter DONE with done=1 and busy=0.
REQ-016 SHALL return from DONE to IDLE on the next edge with done=0; total latency is start edge to done high = 32 cycles.
REQ-017 SHALL ignore start in CALC and DONE; SHALL ignore a, b and sign changes after the start edge.
REQ-018 SHALL, on start with b==0, go directly from IDLE to DONE on E0 and output quo=32'hFFFFFFFF, rem=a, dbz=1; this applies to both signed and unsigned operation.
REQ-019 SHALL set dbz=0 for every operation with b!=0.
REQ-020 SHALL update quo, rem and dbz only on entry to DONE and hold them until the next DONE entry.
REQ-021 SHALL, for signed operation, divide magnitudes; quo SHALL be negated when the operand signs differ, and rem SHALL take the sign of the dividend.
REQ-022 SHALL, for signed 0x80000000 / 0xFFFFFFFF, return quo=0x80000000, rem=0, dbz=0, with no trap and no extra cycles.
REQ-023 SHALL treat all arithmetic as 32-bit with a 33-bit partial-remainder subtractor; no result is wider than 32 bits.

Reset
REQ-024 SHALL, when rst_n=0 at any time, immediately force state IDLE and busy=0, done=0, quo=0, rem=0, dbz=0.
REQ-025 SHALL discard any in-flight operation when reset is asserted mid-CALC; no done pulse follows.
REQ-026 SHALL accept a new start on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL recognise the macro DIVIDER_SIGNED_EN.
REQ-028 SHALL, with DIVIDER_SIGNED_EN defined, honour sign as specified in REQ-021 and REQ-022.
REQ-029 SHALL, without DIVIDER_SIGNED_EN, ignore sign, perform unsigned division only, and omit the sign-correction logic; port list and timing are unchanged.

Verification
REQ-030 SHALL cover: unsigned a=100, b=7 -> done exactly 32 cycles after start, quo=14, rem=2, dbz=0.
REQ-031 SHALL cover: a=0x12345678, b=0 -> done on the cycle after start, quo=0xFFFFFFFF, rem=0x12345678, dbz=1.
REQ-032 SHALL cover, with DIVIDER_SIGNED_EN: sign=1, a=0xFFFFFFF9 (-7), b=2 -> quo=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
REQ-033 SHALL cover: sign=1, a=0x80000000, b=0xFFFFFFFF -> with DIVIDER_SIGNED_EN quo=0x80000000, rem=0; without it quo=0, rem=0x80000000.
REQ-034 SHALL cover: start with a=100, b=7, second start with a=9, b=3 at cycle 5, then rst_n low at cycle 10 -> the second start is ignored, busy=0 and all outputs=0 immediately, no done pulse, and a start after release completes normally.
